// File: rtl/cr_cddip_osf_cqe_ctl.sv
// rtl/cr_cddip_osf_cqe_ctl.sv - OSF CQE FIFO and host presentation controller with supervisor halt/exit handshake (optional CR_CDDIP_OSF_EXIT_CNT_EN exit total)
module cr_cddip_osf_cqe_ctl #(
    parameter int DEPTH = 8,
    parameter int CQE_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cqe_in_vld,
    input  logic [CQE_W-1:0]           cqe_in_data,
    output logic                       cqe_in_rdy,
    output logic                       cqe_out_vld,
    output logic [CQE_W-1:0]           cqe_out_data,
    input  logic                       cqe_out_rdy,
    input  logic                       sup_osf_halt,
    output logic                       osf_sup_cqe_exit,
    output logic [$clog2(DEPTH+1)-1:0] osf_cnt,
`ifdef CR_CDDIP_OSF_EXIT_CNT_EN
    output logic [31:0]                osf_exit_total,
`endif
    output logic                       osf_busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CQE_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               push;
    logic               pop;

    assign cqe_in_rdy   = (cnt < CNT_W'(DEPTH));
    assign cqe_out_vld  = (state == PRESENT);
    assign cqe_out_data = mem[rd_ptr];
    assign push         = cqe_in_vld && cqe_in_rdy;
    assign pop          = cqe_out_vld && cqe_out_rdy;
    assign osf_cnt      = cnt;
    assign osf_busy     = (cnt != '0) || cqe_out_vld;

    // FIFO storage; entries are not reset, a flushed count makes them unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cqe_in_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Presentation state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: halt only gates new presentations, never withdraws a valid CQE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sup_osf_halt) begin
                    state_nxt = HALTED;
                end else if (cnt != '0) begin
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (cqe_out_rdy) begin
                    if (sup_osf_halt) begin
                        state_nxt = HALTED;
                    end else if (cnt > CNT_W'(1)) begin
                        state_nxt = PRESENT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HALTED: begin
                if (!sup_osf_halt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One registered exit pulse per accepted CQE, so the supervisor sees every delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osf_sup_cqe_exit <= 1'b0;
        end else begin
            osf_sup_cqe_exit <= pop;
        end
    end

`ifdef CR_CDDIP_OSF_EXIT_CNT_EN
    // Saturating delivery total, updated on the same edge that raises the exit pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osf_exit_total <= '0;
        end else if (pop && (osf_exit_total != 32'hFFFF_FFFF)) begin
            osf_exit_total <= osf_exit_total + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(cqe_in_vld && cqe_in_rdy && (cnt == CNT_W'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (cnt == '0)));

endmodule
